// File: rtl/data_ram_responder.sv
// -----------------------------------------------------------------------------
// data_ram_responder
//
// Responder end of the data-RAM interface driven by the MEM stage. A request
// is taken in IDLE, the pipeline is held with ram_stall for WAIT_STATES extra
// cycles, and the access is then completed against an internal word array.
// ram_ready pulses for one cycle (the RESP cycle) to mark completion.
//
// Parameters
//   ADDR_WIDTH   word-index bits; the array holds 2**ADDR_WIDTH 32-bit words.
//   WAIT_STATES  extra busy cycles per access (0..15).
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   ram_en          request valid, held stable by MEM while ram_stall=1
//   ram_write_en    byte-lane write enables; 4'b0000 means read
//   ram_addr        byte address (bits [1:0] are always 0)
//   ram_write_data  lane-aligned write data
//   ram_read_data   registered read word, valid from RESP until next read
//   ram_ready       one-cycle completion pulse
//   ram_stall       combinational pipeline hold request
//   ram_error       out-of-range pulse, coincident with ram_ready
//   stat_reads      (DATA_RAM_STATS_EN only) count of in-range reads
//   stat_writes     (DATA_RAM_STATS_EN only) count of in-range writes
//
// Handshake: MEM raises ram_en with a stable request; while ram_stall=1 the
// request must not change. The request completes in the cycle ram_ready=1;
// ram_en seen in that cycle belongs to the completed request and is ignored.
// A new request may be accepted in the very next (IDLE) cycle.
//
// Optional feature macro: DATA_RAM_STATS_EN adds the access counters.
// -----------------------------------------------------------------------------
module data_ram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ram_en,
  input  logic [3:0]  ram_write_en,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_write_data,
  output logic [31:0] ram_read_data,
  output logic        ram_ready,
  output logic        ram_stall,
  output logic        ram_error
`ifdef DATA_RAM_STATS_EN
  ,
  output logic [31:0] stat_reads,
  output logic [31:0] stat_writes
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
  localparam int         DEPTH     = 1 << ADDR_WIDTH;

  // FSM state, kept as a plainly named signal so checkers can bind to it.
  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [3:0]  wait_cnt;

  // Latched request (word address only; byte offset is always zero).
  logic [29:0] word_q;
  logic [3:0]  we_q;
  logic [31:0] wdata_q;

  // Operands of the access performed on the edge that enters RESP.
  logic [29:0]           acc_word;
  logic [3:0]            acc_we;
  logic [31:0]           acc_wdata;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic                  acc_oor;
  logic                  acc_is_write;
  logic                  enter_resp;
  logic [31:0]           rd_word;

  logic [31:0] mem [DEPTH];

  // Byte offset bits carry no information; they are deliberately unused.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^ram_addr[1:0];

  // With WAIT_STATES=0 RESP is entered straight from IDLE, before anything
  // has been latched, so the access must use the live inputs in that case.
  always_comb begin
    acc_word  = word_q;
    acc_we    = we_q;
    acc_wdata = wdata_q;
    if (state == ST_IDLE) begin
      acc_word  = ram_addr[31:2];
      acc_we    = ram_write_en;
      acc_wdata = ram_write_data;
    end
  end

  assign acc_idx      = acc_word[ADDR_WIDTH-1:0];
  assign acc_oor      = |acc_word[29:ADDR_WIDTH];
  assign acc_is_write = |acc_we;
  assign rd_word      = mem[acc_idx];

  // rst_n gating keeps an access from being performed while reset is held
  // (relevant when WAIT_STATES=0 and ram_en is high during reset).
  assign enter_resp = rst_n && (next_state == ST_RESP);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (ram_en) begin
          next_state = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt <= 4'd1) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign ram_stall = rst_n &&
                     (((state == ST_IDLE) && ram_en) || (state == ST_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wait_cnt      <= 4'd0;
      word_q        <= '0;
      we_q          <= '0;
      wdata_q       <= '0;
      ram_read_data <= '0;
      ram_ready     <= 1'b0;
      ram_error     <= 1'b0;
    end else begin
      state     <= next_state;
      ram_ready <= enter_resp;
      ram_error <= enter_resp && acc_oor;

      if ((state == ST_IDLE) && ram_en) begin
        word_q   <= ram_addr[31:2];
        we_q     <= ram_write_en;
        wdata_q  <= ram_write_data;
        wait_cnt <= WAIT_LOAD;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      // Writes leave the read register alone unless out of range.
      if (enter_resp) begin
        if (acc_oor) begin
          ram_read_data <= '0;
        end else if (!acc_is_write) begin
          ram_read_data <= rd_word;
        end
      end
    end
  end

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_is_write && !acc_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_we[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

`ifdef DATA_RAM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_reads  <= '0;
      stat_writes <= '0;
    end else if (enter_resp && !acc_oor) begin
      if (acc_is_write) begin
        stat_writes <= stat_writes + 32'd1;
      end else begin
        stat_reads <= stat_reads + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_ram_responder.sv
// -----------------------------------------------------------------------------
// Testbench for data_ram_responder: table of directed accesses on a
// WAIT_STATES=1 instance, plus hand sequences for reset, mid-access reset,
// back-to-back requests and a WAIT_STATES=0 instance.
// -----------------------------------------------------------------------------
module tb_data_ram_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WAIT_STATES=1 instance
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        ram_ready;
  logic        ram_stall;
  logic        ram_error;

  // WAIT_STATES=0 instance
  logic        z_en;
  logic [3:0]  z_we;
  logic [31:0] z_addr;
  logic [31:0] z_wdata;
  logic [31:0] z_rdata;
  logic        z_ready;
  logic        z_stall;
  logic        z_error;

  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ram_en(ram_en), .ram_write_en(ram_write_en),
    .ram_addr(ram_addr), .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data), .ram_ready(ram_ready),
    .ram_stall(ram_stall), .ram_error(ram_error)
  );

  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ram_en(z_en), .ram_write_en(z_we),
    .ram_addr(z_addr), .ram_write_data(z_wdata),
    .ram_read_data(z_rdata), .ram_ready(z_ready),
    .ram_stall(z_stall), .ram_error(z_error)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_access(input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err,
                           output int stalls, output int readies);
    bit got;
    got = 0; stalls = 0; readies = 0; rdata = 'x; err = 1'bx;
    @(posedge clk); #1;
    ram_en = 1'b1; ram_write_en = we; ram_addr = addr; ram_write_data = wdata;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ram_stall) stalls++;
      if (ram_ready) begin
        got = 1; readies++;
        rdata = ram_read_data; err = ram_error;
      end
    end
    @(posedge clk); #1;
    ram_en = 1'b0; ram_write_en = 4'b0000;
    @(negedge clk);
    if (ram_ready) readies++;
  endtask

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          st, rdy;
    int          rdy_idx[$];
    logic [31:0] rdy_dat[$];

    vecs[0]  = '{4'hF, 32'h0000_0010, 32'h1122_3344, 32'h0000_0000, 1'b0};
    vecs[1]  = '{4'h0, 32'h0000_0010, 32'h0,         32'h1122_3344, 1'b0};
    vecs[2]  = '{4'h2, 32'h0000_0010, 32'h0000_AB00, 32'h1122_3344, 1'b0};
    vecs[3]  = '{4'h0, 32'h0000_0010, 32'h0,         32'h1122_AB44, 1'b0};
    vecs[4]  = '{4'hF, 32'h0000_0000, 32'hCAFE_F00D, 32'h1122_AB44, 1'b0};
    vecs[5]  = '{4'hF, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
    vecs[6]  = '{4'h0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1};
    vecs[7]  = '{4'h0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[8]  = '{4'hF, 32'h0000_0020, 32'h5566_7788, 32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{4'h9, 32'h0000_0020, 32'hAA00_00BB, 32'hCAFE_F00D, 1'b0};
    vecs[10] = '{4'h0, 32'h0000_0020, 32'h0,         32'hAA66_77BB, 1'b0};
    vecs[11] = '{4'hF, 32'h0000_0FFC, 32'h0BAD_C0DE, 32'hAA66_77BB, 1'b0};
    vecs[12] = '{4'h0, 32'h0000_0FFC, 32'h0,         32'h0BAD_C0DE, 1'b0};
    vecs[13] = '{4'h0, 32'h8000_0010, 32'h0,         32'h0000_0000, 1'b1};
    vecs[14] = '{4'hF, 32'h0000_0014, 32'h9988_7766, 32'h0000_0000, 1'b0};
    vecs[15] = '{4'h0, 32'h0000_0014, 32'h0,         32'h9988_7766, 1'b0};

    // ---------- reset state (ram_en high during reset must not stall) ----------
    ram_en = 1'b1; ram_write_en = 4'b0000; ram_addr = 32'h10; ram_write_data = '0;
    z_en = 1'b1; z_we = 4'b0000; z_addr = 32'h40; z_wdata = '0;
    #22;
    chk("rst_stall", 32'(ram_stall), 32'd0);
    chk("rst_ready", 32'(ram_ready), 32'd0);
    chk("rst_error", 32'(ram_error), 32'd0);
    chk("rst_rdata", ram_read_data, 32'd0);
    chk("rst_z_stall", 32'(z_stall), 32'd0);
    chk("rst_z_ready", 32'(z_ready), 32'd0);
    ram_en = 1'b0; z_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // ---------- table of accesses ----------
    for (int i = 0; i < 16; i++) begin
      do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, st, rdy);
      exp_q.push_back(vecs[i].exp_rdata);
      chk($sformatf("v%0d_rdata", i), rd, exp_q.pop_front());
      chk($sformatf("v%0d_error", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_stall_cycles", i), 32'(st), 32'd2);
      chk($sformatf("v%0d_ready_pulses", i), 32'(rdy), 32'd1);
    end

    // ---------- back-to-back reads with ram_en held high ----------
    @(posedge clk); #1;
    ram_en = 1'b1; ram_write_en = 4'b0000; ram_addr = 32'h10;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ram_ready) begin
        rdy_idx.push_back(c);
        rdy_dat.push_back(ram_read_data);
        if (rdy_idx.size() == 1) begin
          @(posedge clk); #1; ram_addr = 32'h14;
        end else if (rdy_idx.size() == 2) begin
          @(posedge clk); #1; ram_en = 1'b0;
        end
      end
    end
    ram_en = 1'b0;
    chk("b2b_pulses", 32'(rdy_idx.size()), 32'd2);
    if (rdy_idx.size() >= 2) begin
      chk("b2b_first_idx", 32'(rdy_idx[0]), 32'd2);
      chk("b2b_second_idx", 32'(rdy_idx[1]), 32'd5);
      chk("b2b_first_data", rdy_dat[0], 32'h1122_AB44);
      chk("b2b_second_data", rdy_dat[1], 32'h9988_7766);
    end

    // ---------- reset during WAIT of a write ----------
    do_access(4'h0, 32'h10, 32'h0, rd, er, st, rdy);
    chk("pre_rst_rdata", rd, 32'h1122_AB44);
    @(posedge clk); #1;
    ram_en = 1'b1; ram_write_en = 4'hF; ram_addr = 32'h20; ram_write_data = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_wait_stall", 32'(ram_stall), 32'd1);
    #2 rst_n = 1'b0; ram_en = 1'b0; ram_write_en = 4'h0;
    #1;
    chk("midrst_stall", 32'(ram_stall), 32'd0);
    chk("midrst_rdata", ram_read_data, 32'd0);
    chk("midrst_ready", 32'(ram_ready), 32'd0);
    chk("midrst_error", 32'(ram_error), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    do_access(4'h0, 32'h20, 32'h0, rd, er, st, rdy);
    chk("midrst_old_contents", rd, 32'hAA66_77BB);
    chk("midrst_read_pulses", 32'(rdy), 32'd1);

    // ---------- WAIT_STATES=0 instance ----------
    @(posedge clk); #1;
    z_en = 1'b1; z_we = 4'hF; z_addr = 32'h40; z_wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    chk("ws0_wr_accept_stall", 32'(z_stall), 32'd1);
    chk("ws0_wr_accept_ready", 32'(z_ready), 32'd0);
    @(negedge clk);
    chk("ws0_wr_resp_stall", 32'(z_stall), 32'd0);
    chk("ws0_wr_resp_ready", 32'(z_ready), 32'd1);
    chk("ws0_wr_resp_error", 32'(z_error), 32'd0);
    @(posedge clk); #1;
    z_en = 1'b0; z_we = 4'h0;
    @(posedge clk); #1;
    z_en = 1'b1; z_addr = 32'h40;
    @(negedge clk);
    chk("ws0_rd_accept_stall", 32'(z_stall), 32'd1);
    @(negedge clk);
    chk("ws0_rd_resp_ready", 32'(z_ready), 32'd1);
    chk("ws0_rd_resp_stall", 32'(z_stall), 32'd0);
    chk("ws0_rd_data", z_rdata, 32'hA5A5_5A5A);
    @(posedge clk); #1;
    z_en = 1'b0;
    @(negedge clk);
    chk("ws0_ready_drop", 32'(z_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Responder end of the data-RAM interface driven by the MEM stage.
- Accepts word-aligned requests with per-byte write enables, holds the pipeline with a stall signal during configurable wait states, then completes the access against an internal word array.
- Returns read data with a one-cycle ready pulse.
- Sits between MEM/WB and the pipeline stall controller; stands in for the external data SRAM in simulation and FPGA builds.

Parameters:
- ADDR_WIDTH, 10, word-index bits; depth = 2^ADDR_WIDTH words (4 KiB default).
- WAIT_STATES, 1, extra busy cycles per access; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- ram_en  input  1  request valid; held stable by MEM while ram_stall=1.
- ram_write_en  input  4  byte-lane write enables; 4'b0000 with ram_en=1 means read.
- ram_addr  input  32  byte address; bits [1:0] always 0 from MEM.
- ram_write_data  input  32  lane-aligned write data.
- ram_read_data  output  32  read word, registered.
- ram_ready  output  1  one-cycle completion pulse.
- ram_stall  output  1  pipeline hold request.
- ram_error  output  1  out-of-range pulse, coincident with ram_ready.

Behaviour:
- Reset is asynchronous, active-low, on rst_n.
- Reset values: ram_read_data=0, ram_ready=0, ram_error=0, state=IDLE, wait counter=0.
- Memory array is not cleared by reset.
- ram_stall is combinational: 1 when (state==IDLE && ram_en) or state==WAIT; otherwise 0. Reset forces it to 0.
- States:
  - IDLE: if ram_en=1, latch addr, write_en and write_data, and load counter with WAIT_STATES. Next state is WAIT if WAIT_STATES>0, otherwise RESP.
  - WAIT: decrement the counter each cycle. When the counter is 1, go to RESP.
  - RESP: perform the access on entry edge. ram_ready=1 for exactly this cycle. Always return to IDLE. ram_en seen in RESP is the just-completed request and is never re-accepted.
- Latency: acceptance cycle plus WAIT_STATES cycles of stall, then RESP. Total stall = WAIT_STATES+1 cycles.
- Word index = latched addr[ADDR_WIDTH+1:2].
- Out of range when addr[31:ADDR_WIDTH+2] != 0:
  - write is dropped;
  - ram_read_data is set to 0;
  - ram_error=1 during RESP.
- Write: for each lane i with write_en[i]=1, mem[idx][8i+7:8i] <= write_data[8i+7:8i]; other lanes are unchanged. ram_read_data holds its previous value.
- Read: ram_read_data <= mem[idx], valid from the RESP cycle until the next read completes.
- Inputs are sampled only in IDLE; changes during WAIT are ignored.
- Reset mid-access (WAIT or RESP): the access is abandoned, and no write occurs if the write edge had not yet been reached. All outputs go to reset values immediately.
- Back-to-back requests: a new request may be accepted in the IDLE cycle directly after RESP. There is no idle gap requirement.

Optional Feature:
- Macro DATA_RAM_STATS_EN.
- Defined: adds output ports stat_reads[31:0] and stat_writes[31:0].
  - Each increments by 1 in the RESP cycle of an in-range read or write respectively.
  - Both wrap at 2^32 and reset to 0.
  - Out-of-range accesses are not counted.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan (defaults WAIT_STATES=1, ADDR_WIDTH=10):
- Word write then read: write 0x11223344 to 0x00000010 with we=1111, then read 0x00000010. ram_stall is high 2 cycles per access, ram_ready pulses once each, read returns 0x11223344.
- Byte merge: after the above, write 0x0000AB00 with we=0010, then read. Returns 0x1122AB44.
- Out of range: write 0xDEADBEEF to 0x00001000. ram_error=1 with ram_ready, array unchanged; a read of the same address returns 0 with ram_error=1.
- Reset mid-access: assert rst_n=0 during WAIT of a write to 0x20. Outputs go to 0 immediately, stall drops, and a later read of 0x20 returns the old contents.
- Back-to-back: read 0x10 and read 0x14 with ram_en held high continuously. Exactly two ready pulses, 2 cycles apart after each acceptance; no duplicate acceptance in RESP.
- WAIT_STATES=0 build: stall is high only in the acceptance cycle, and ram_ready appears in the following cycle.
